pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Configurable pipeline stage register with stall, flush, valid and self-decrementing Tnew.
// Define PIPE_STAGE_REG_BUBBLE_CNT_EN to add the BubbleCnt bubble-cycle counter.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W   = 31,
  parameter int unsigned TNEW_LSB = 8,
  parameter int unsigned TNEW_W   = 3,
  parameter int unsigned NDATA    = 2,
  parameter int unsigned DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Stall,
  input  logic                    Flush,
  input  logic                    ValidIn,
  input  logic [31:0]             InsIn,
  input  logic [31:0]             PCIn,
  input  logic [NDATA*DATA_W-1:0] DataIn,
  input  logic [CTRL_W-1:0]       CtrlIn,
  output logic                    ValidOut,
  output logic [31:0]             InsOut,
  output logic [31:0]             PCOut,
  output logic [NDATA*DATA_W-1:0] DataOut,
  output logic [CTRL_W-1:0]       CtrlOut,
`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
  output logic [31:0]             BubbleCnt,
`endif
  output logic [TNEW_W-1:0]       TNewOut
);

  if ((TNEW_LSB + TNEW_W > CTRL_W) || (NDATA < 1) || (NDATA > 4))
  begin : g_param_check
    $error("pipe_stage_reg: illegal parameter combination");
  end

  localparam logic [CTRL_W-1:0] TNEW_MASK =
    CTRL_W'({TNEW_W{1'b1}}) << TNEW_LSB;

  function automatic logic [TNEW_W-1:0] sat_dec(
    input logic [TNEW_W-1:0] x
  );
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  logic                    valid_q;
  logic [31:0]             ins_q;
  logic [31:0]             pc_q;
  logic [NDATA*DATA_W-1:0] data_q;
  logic [CTRL_W-1:0]       ctrl_q;
  logic [TNEW_W-1:0]       tnew_q;
  logic                    bubble;

  // A load without a real instruction is just another way to insert a bubble.
  assign bubble = Flush || (!Stall && !ValidIn);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      ctrl_q  <= '0;
      tnew_q  <= '0;
    end else if (bubble) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
      pc_q    <= PCIn;
      data_q  <= '0;
      ctrl_q  <= '0;
      tnew_q  <= '0;
    end else if (Stall) begin
      tnew_q  <= sat_dec(tnew_q);
    end else begin
      valid_q <= 1'b1;
      ins_q   <= InsIn;
      pc_q    <= PCIn;
      data_q  <= DataIn;
      ctrl_q  <= CtrlIn;
      tnew_q  <= sat_dec(CtrlIn[TNEW_LSB +: TNEW_W]);
    end
  end

  assign ValidOut = valid_q;
  assign InsOut   = ins_q;
  assign PCOut    = pc_q;
  assign DataOut  = data_q;
  assign TNewOut  = tnew_q;

  // Bubbles hold an all-zero ctrl, so CtrlOut is zero without gating.
  assign CtrlOut = (ctrl_q & ~TNEW_MASK)
                 | (CTRL_W'(tnew_q) << TNEW_LSB);

`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
  logic [31:0] bcnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bcnt_q <= '0;
    end else if (!valid_q && (bcnt_q != 32'hFFFF_FFFF)) begin
      bcnt_q <= bcnt_q + 32'd1;
    end
  end

  assign BubbleCnt = bcnt_q;
`endif

endmodule
